// File: rtl/tour_cmd_seq_if.sv
// Command handshake between the tour sequencer and cmd_proc.
// The sequencer (master) drives cmd/cmd_rdy/resp; cmd_proc (slave) returns the acknowledges.
interface tour_cmd_seq_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (output cmd, cmd_rdy, resp, input clr_cmd_rdy, send_resp);
  modport slave  (input cmd, cmd_rdy, resp, output clr_cmd_rdy, send_resp);
endinterface

// File: rtl/tour_cmd_seq.sv
// Knight-tour command sequencer: splits each one-hot move into two single-axis
// commands for cmd_proc, with UART passthrough while idle.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES  = 24,
  parameter int unsigned IDX_W      = 5,
  parameter bit          VERT_FIRST = 1'b0,
  parameter logic [7:0]  RESP_DONE  = 8'hA5,
  parameter logic [7:0]  RESP_BUSY  = 8'h5A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic             abort,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  tour_cmd_seq_if.master   cp,
  output logic             tour_busy,
  output logic             tour_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEG1, S_HOLD1, S_LEG2, S_HOLD2} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             err_nxt, busy_nxt;
  logic [7:0]       resp_nxt;

  logic [1:0]  h_sq, v_sq;
  logic        h_pos, v_pos, legal;
  logic [15:0] h_cmd, v_cmd, leg1_cmd, leg2_cmd;

  // One-hot move -> per-axis magnitude and direction; anything else is illegal
  always_comb begin
    h_sq  = 2'd0;
    v_sq  = 2'd0;
    h_pos = 1'b0;
    v_pos = 1'b0;
    legal = 1'b1;
    case (move)
      8'h01:   begin h_sq = 2'd1; h_pos = 1'b0; v_sq = 2'd2; v_pos = 1'b1; end
      8'h02:   begin h_sq = 2'd1; h_pos = 1'b1; v_sq = 2'd2; v_pos = 1'b1; end
      8'h04:   begin h_sq = 2'd2; h_pos = 1'b0; v_sq = 2'd1; v_pos = 1'b1; end
      8'h08:   begin h_sq = 2'd2; h_pos = 1'b0; v_sq = 2'd1; v_pos = 1'b0; end
      8'h10:   begin h_sq = 2'd1; h_pos = 1'b0; v_sq = 2'd2; v_pos = 1'b0; end
      8'h20:   begin h_sq = 2'd1; h_pos = 1'b1; v_sq = 2'd2; v_pos = 1'b0; end
      8'h40:   begin h_sq = 2'd2; h_pos = 1'b1; v_sq = 2'd1; v_pos = 1'b0; end
      8'h80:   begin h_sq = 2'd2; h_pos = 1'b1; v_sq = 2'd1; v_pos = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  assign h_cmd    = {4'h2, (h_pos ? 8'hBF : 8'h3F), 2'b00, h_sq};
  assign v_cmd    = {4'h3, (v_pos ? 8'h00 : 8'h7F), 2'b00, v_sq};
  assign leg1_cmd = VERT_FIRST ? v_cmd : h_cmd;
  assign leg2_cmd = VERT_FIRST ? h_cmd : v_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mv_indx   <= '0;
      tour_err  <= 1'b0;
      tour_busy <= 1'b0;
      cp.resp   <= RESP_DONE;
    end else begin
      state     <= state_nxt;
      mv_indx   <= idx_nxt;
      tour_err  <= err_nxt;
      tour_busy <= busy_nxt;
      cp.resp   <= resp_nxt;
    end
  end

  // Next state plus the combinational cmd mux; abort outranks every handshake
  always_comb begin
    state_nxt  = state;
    idx_nxt    = mv_indx;
    err_nxt    = tour_err;
    cp.cmd     = cmd_UART;
    cp.cmd_rdy = cmd_rdy_UART;
    case (state)
      S_IDLE: begin
        if (start_tour && !abort) begin
          idx_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = S_LEG1;
        end
      end
      S_LEG1: begin
        cp.cmd     = leg1_cmd;
        cp.cmd_rdy = legal;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (!legal) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (cp.clr_cmd_rdy) begin
          state_nxt = S_HOLD1;
        end
      end
      S_HOLD1: begin
        cp.cmd     = leg1_cmd;
        cp.cmd_rdy = 1'b0;
        if (abort)             state_nxt = S_IDLE;
        else if (cp.send_resp) state_nxt = S_LEG2;
      end
      S_LEG2: begin
        cp.cmd     = leg2_cmd;
        cp.cmd_rdy = 1'b1;
        if (abort)               state_nxt = S_IDLE;
        else if (cp.clr_cmd_rdy) state_nxt = S_HOLD2;
      end
      S_HOLD2: begin
        cp.cmd     = leg2_cmd;
        cp.cmd_rdy = 1'b0;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cp.send_resp) begin
          if (mv_indx == LAST_IDX) begin
            state_nxt = S_IDLE;
          end else begin
            idx_nxt   = mv_indx + IDX_W'(1);
            state_nxt = S_LEG1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered status tracks the state being entered
  always_comb begin
    busy_nxt = (state_nxt != S_IDLE);
    resp_nxt = RESP_DONE;
    if (state_nxt == S_LEG1 || state_nxt == S_HOLD1 || state_nxt == S_LEG2)
      resp_nxt = RESP_BUSY;
    else if (state_nxt == S_HOLD2 && idx_nxt != LAST_IDX)
      resp_nxt = RESP_BUSY;
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: randomized tours against a knight-move
// reference model, plus reset, abort, illegal-move and axis-order scenarios.
module tb_tour_cmd_seq;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned NUM_MOVES = 24;
  localparam logic [7:0]  DONE      = 8'hA5;
  localparam logic [7:0]  BUSY      = 8'h5A;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_tour = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [7:0]       move, move1;
  logic [IDX_W-1:0] mv_indx, mv_indx1;
  logic [15:0]      cmd_UART = 16'h0;
  logic             cmd_rdy_UART = 1'b0;
  logic             tour_busy, tour_err, tour_busy1, tour_err1;
  logic [7:0]       mv_tab [32];
  int               n_vec = 0, n_err = 0, rdy_rise = 0;
  logic             rdy_q;

  tour_cmd_seq_if if0 ();
  tour_cmd_seq_if if1 ();

  tour_cmd_seq #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W), .VERT_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .abort(abort), .move(move),
    .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cp(if0),
    .tour_busy(tour_busy), .tour_err(tour_err));

  tour_cmd_seq #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W), .VERT_FIRST(1'b1)) dut_v (
    .clk(clk), .rst_n(rst_n), .start_tour(start1), .abort(abort1), .move(move1),
    .mv_indx(mv_indx1), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cp(if1),
    .tour_busy(tour_busy1), .tour_err(tour_err1));

  always #10 clk = ~clk;

  // Upstream move store: combinational read at each sequencer's index
  always_comb move  = mv_tab[mv_indx];
  always_comb move1 = mv_tab[mv_indx1];

  always @(posedge clk) begin
    rdy_q <= if0.cmd_rdy;
    if (if0.cmd_rdy === 1'b1 && rdy_q === 1'b0) rdy_rise <= rdy_rise + 1;
  end

  // Reference: knight displacement table -> single-axis command
  function automatic logic [15:0] ref_cmd(input logic [7:0] m, input bit vert);
    int dxs [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int dys [8] = '{ 2, 2, 1, -1, -2, -2, -1, 1};
    int b = 0;
    for (int i = 0; i < 8; i++) if (m[i]) b = i;
    if (vert)
      return {4'h3, (dys[b] > 0) ? 8'h00 : 8'h7F, 4'((dys[b] > 0) ? dys[b] : -dys[b])};
    return {4'h2, (dxs[b] > 0) ? 8'hBF : 8'h3F, 4'((dxs[b] > 0) ? dxs[b] : -dxs[b])};
  endfunction

  function automatic logic [7:0] rand_move();
    return 8'(1 << $urandom_range(0, 7));
  endfunction

  // One leg on dut: LEG state for a random number of cycles, then its HOLD state
  task automatic do_leg(input logic [15:0] exp, input int idx, input bit last, input bit noise);
    int w;
    logic [7:0] hresp;
    hresp = last ? DONE : BUSY;
    w = $urandom_range(0, 2);
    for (int k = 0; k <= w; k++) begin
      n_vec++;
      if (if0.cmd !== exp || if0.cmd_rdy !== 1'b1 || mv_indx !== IDX_W'(idx) ||
          if0.resp !== BUSY || tour_busy !== 1'b1) begin
        n_err++;
        $display("FAIL leg idx=%0d: cmd=%h rdy=%b indx=%0d resp=%h busy=%b, want cmd=%h rdy=1 indx=%0d resp=%h busy=1",
                 idx, if0.cmd, if0.cmd_rdy, mv_indx, if0.resp, tour_busy, exp, idx, BUSY);
      end
      if (k == w) if0.clr_cmd_rdy = 1'b1;
      else if (noise) begin if0.send_resp = 1'b1; start_tour = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      if0.clr_cmd_rdy = 1'b0; if0.send_resp = 1'b0; start_tour = 1'b0;
    end
    w = $urandom_range(0, 2);
    for (int k = 0; k <= w; k++) begin
      n_vec++;
      if (if0.cmd !== exp || if0.cmd_rdy !== 1'b0 || mv_indx !== IDX_W'(idx) || if0.resp !== hresp) begin
        n_err++;
        $display("FAIL hold idx=%0d: cmd=%h rdy=%b indx=%0d resp=%h, want cmd=%h rdy=0 indx=%0d resp=%h",
                 idx, if0.cmd, if0.cmd_rdy, mv_indx, if0.resp, exp, idx, hresp);
      end
      if (k == w) if0.send_resp = 1'b1;
      else if (noise) begin if0.clr_cmd_rdy = 1'b1; start_tour = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      if0.clr_cmd_rdy = 1'b0; if0.send_resp = 1'b0; start_tour = 1'b0;
    end
  endtask

  task automatic kick_tour();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] c;
    logic r;
    rst_n = 1'b0; cmd_UART = 16'h2BF1; cmd_rdy_UART = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (tour_busy !== 1'b0 || tour_err !== 1'b0 || mv_indx !== '0 || if0.resp !== DONE) begin
      n_err++;
      $display("FAIL reset_values: busy=%b err=%b indx=%0d resp=%h, want 0 0 0 %h",
               tour_busy, tour_err, mv_indx, if0.resp, DONE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (if0.cmd !== 16'h2BF1 || if0.cmd_rdy !== 1'b1 || if0.resp !== DONE || tour_busy !== 1'b0) begin
      n_err++;
      $display("FAIL uart_pass: cmd=%h rdy=%b resp=%h busy=%b, want 2bf1 1 a5 0",
               if0.cmd, if0.cmd_rdy, if0.resp, tour_busy);
    end
    for (int i = 0; i < 4; i++) begin
      c = 16'($urandom); r = 1'($urandom_range(0, 1));
      cmd_UART = c; cmd_rdy_UART = r;
      #1;
      n_vec++;
      if (if0.cmd !== c || if0.cmd_rdy !== r) begin
        n_err++;
        $display("FAIL uart_rand: cmd=%h rdy=%b, want %h %b", if0.cmd, if0.cmd_rdy, c, r);
      end
      @(negedge clk);
    end
    cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_basic();
    mv_tab[0] = 8'h02; mv_tab[1] = 8'h80;
    abort = 1'b1; start_tour = 1'b1;
    @(negedge clk);
    abort = 1'b0; start_tour = 1'b0;
    n_vec++;
    if (tour_busy !== 1'b0) begin
      n_err++; $display("FAIL idle_abort_start: busy=%b, want 0", tour_busy);
    end
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    kick_tour();
    do_leg(16'h2BF1, 0, 1'b0, 1'b0);
    do_leg(16'h3002, 0, 1'b0, 1'b0);
    n_vec++;
    if (mv_indx !== IDX_W'(1) || if0.cmd !== 16'h2BF2 || if0.cmd_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL next_move: indx=%0d cmd=%h rdy=%b, want 1 2bf2 1", mv_indx, if0.cmd, if0.cmd_rdy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_vert_first();
    mv_tab[0] = 8'h40;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n_vec++;
    if (if1.cmd !== 16'h37F1 || if1.cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL vf_leg1: cmd=%h rdy=%b, want 37f1 1", if1.cmd, if1.cmd_rdy);
    end
    if1.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    if1.clr_cmd_rdy = 1'b0;
    if1.send_resp = 1'b1;
    @(negedge clk);
    if1.send_resp = 1'b0;
    n_vec++;
    if (if1.cmd !== 16'h2BF2 || if1.cmd_rdy !== 1'b1) begin
      n_err++; $display("FAIL vf_leg2: cmd=%h rdy=%b, want 2bf2 1", if1.cmd, if1.cmd_rdy);
    end
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    n_vec++;
    if (tour_busy1 !== 1'b0) begin
      n_err++; $display("FAIL vf_abort: busy=%b, want 0", tour_busy1);
    end
  endtask

  task automatic test_full_tour();
    int base;
    for (int i = 0; i < 32; i++) mv_tab[i] = rand_move();
    cmd_rdy_UART = 1'b0;
    base = rdy_rise;
    kick_tour();
    for (int i = 0; i < int'(NUM_MOVES); i++) begin
      do_leg(ref_cmd(mv_tab[i], 1'b0), i, 1'b0, 1'b1);
      do_leg(ref_cmd(mv_tab[i], 1'b1), i, i == int'(NUM_MOVES) - 1, 1'b1);
    end
    n_vec++;
    if (tour_busy !== 1'b0 || mv_indx !== IDX_W'(NUM_MOVES - 1) || if0.resp !== DONE ||
        rdy_rise - base != 2 * int'(NUM_MOVES)) begin
      n_err++;
      $display("FAIL tour_end: busy=%b indx=%0d resp=%h pulses=%0d, want 0 %0d a5 %0d",
               tour_busy, mv_indx, if0.resp, rdy_rise - base, NUM_MOVES - 1, 2 * NUM_MOVES);
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 5; i++) mv_tab[i] = rand_move();
    mv_tab[5] = 8'h03;
    kick_tour();
    for (int i = 0; i < 5; i++) begin
      do_leg(ref_cmd(mv_tab[i], 1'b0), i, 1'b0, 1'b0);
      do_leg(ref_cmd(mv_tab[i], 1'b1), i, 1'b0, 1'b0);
    end
    n_vec++;
    if (if0.cmd_rdy !== 1'b0 || mv_indx !== IDX_W'(5)) begin
      n_err++; $display("FAIL illegal_rdy: rdy=%b indx=%0d, want 0 5", if0.cmd_rdy, mv_indx);
    end
    @(negedge clk);
    n_vec++;
    if (tour_busy !== 1'b0 || tour_err !== 1'b1 || mv_indx !== IDX_W'(5) || if0.resp !== DONE) begin
      n_err++;
      $display("FAIL illegal_idle: busy=%b err=%b indx=%0d resp=%h, want 0 1 5 a5",
               tour_busy, tour_err, mv_indx, if0.resp);
    end
    mv_tab[5] = 8'h01;
    kick_tour();
    n_vec++;
    if (tour_err !== 1'b0 || mv_indx !== '0 || tour_busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart: err=%b indx=%0d busy=%b, want 0 0 1", tour_err, mv_indx, tour_busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] c;
    for (int i = 0; i < 32; i++) mv_tab[i] = rand_move();
    kick_tour();
    do_leg(ref_cmd(mv_tab[0], 1'b0), 0, 1'b0, 1'b1);
    do_leg(ref_cmd(mv_tab[0], 1'b1), 0, 1'b0, 1'b1);
    do_leg(ref_cmd(mv_tab[1], 1'b0), 1, 1'b0, 1'b1);
    c = 16'($urandom);
    cmd_UART = c; cmd_rdy_UART = 1'b1;
    abort = 1'b1; if0.clr_cmd_rdy = 1'b1;
    #1;
    n_vec++;
    if (if0.cmd_rdy !== 1'b1 || if0.cmd !== ref_cmd(mv_tab[1], 1'b1)) begin
      n_err++;
      $display("FAIL abort_same_cycle: rdy=%b cmd=%h, want 1 %h", if0.cmd_rdy, if0.cmd, ref_cmd(mv_tab[1], 1'b1));
    end
    @(negedge clk);
    abort = 1'b0; if0.clr_cmd_rdy = 1'b0;
    n_vec++;
    if (tour_busy !== 1'b0 || if0.cmd !== c || if0.cmd_rdy !== 1'b1 || mv_indx !== IDX_W'(1) ||
        tour_err !== 1'b0 || if0.resp !== DONE) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b cmd=%h rdy=%b indx=%0d err=%b resp=%h, want 0 %h 1 1 0 a5",
               tour_busy, if0.cmd, if0.cmd_rdy, mv_indx, tour_err, if0.resp, c);
    end
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 32; i++) mv_tab[i] = rand_move();
    kick_tour();
    do_leg(ref_cmd(mv_tab[0], 1'b0), 0, 1'b0, 1'b0);
    do_leg(ref_cmd(mv_tab[0], 1'b1), 0, 1'b0, 1'b0);
    do_leg(ref_cmd(mv_tab[1], 1'b0), 1, 1'b0, 1'b0);
    if0.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    if0.clr_cmd_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (tour_busy !== 1'b0 || tour_err !== 1'b0 || mv_indx !== '0 || if0.resp !== DONE ||
        if0.cmd_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b err=%b indx=%0d resp=%h rdy=%b, want 0 0 0 a5 0",
               tour_busy, tour_err, mv_indx, if0.resp, if0.cmd_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mv_tab[i] = 8'h01;
    if0.clr_cmd_rdy = 1'b0; if0.send_resp = 1'b0;
    if1.clr_cmd_rdy = 1'b0; if1.send_resp = 1'b0;
    test_reset();
    test_basic();
    test_vert_first();
    test_full_tour();
    test_illegal();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
